// File: rtl/lcd_arb_pkg.sv
// Shared types and sizing helpers for the panel read arbiter.
// Optional statistics counters are enabled with LCD_ARB_STATS_EN (see lcd_panel_rd_arb).
package lcd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // Channel tag / pointer width: holds 0..NUM_CH inclusive.
    function automatic int ch_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Queue occupancy width: holds 0..DEPTH inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d) + 1;
    endfunction

    function automatic int clamp_act(input int n, input int nch);
        if (n == 0)
            return 1;
        if (n > nch)
            return nch;
        return n;
    endfunction

endpackage

// File: rtl/lcd_skid_q.sv
// Circular skid queue with push/pop/flush; head word reads as zero while empty.
module lcd_skid_q
    import lcd_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             ahb_clk_intf,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [W-1:0]     i_wdata,
    output logic [W-1:0]     o_rdata,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && !i_flush;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge ahb_clk_intf) begin
        if (w_push)
            r_mem[r_wr] <= i_wdata;
    end

    assign o_rdata = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge ahb_clk_intf) disable iff (reset)
        !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/lcd_panel_rd_arb.sv
// Strict round-robin read arbiter over NUM_CH panel FIFOs feeding a credit-checked skid queue.
// Define LCD_ARB_STATS_EN to add the stall_cnt / words_cnt statistics outputs.
module lcd_panel_rd_arb
    import lcd_arb_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int SKID_DEPTH = 2,
    localparam int CH_W  = ch_w(NUM_CH),
    localparam int CNT_W = cnt_w(SKID_DEPTH),
    localparam int NA_W  = $clog2(NUM_CH + 1)
) (
    input  logic                     ahb_clk_intf,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NA_W-1:0]          num_active,
    input  logic                     frame_sync,
    input  logic [NUM_CH-1:0]        fifo_empty,
    input  logic [NUM_CH*DATA_W-1:0] fifo_rdata,
    output logic [NUM_CH-1:0]        fifo_rd_en,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    output logic                     underrun
`ifdef LCD_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt,
    output logic [31:0]              words_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
    } q_entry_t;

    arb_state_e      r_state;
    arb_state_e      w_next;
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] r_act_lat;
    logic [CH_W-1:0] r_ch_d;
    logic [CH_W-1:0] w_act_new;
    logic            r_infl;
    logic            r_rd_seen;
    logic            r_underrun;
    logic            w_issue;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic            w_ptr_empty;
    logic            w_credit;
    logic [CNT_W-1:0] w_count;
    logic [DATA_W-1:0] w_ret_data;
    q_entry_t        w_push_ent;
    q_entry_t        w_head;

    assign w_act_new = CH_W'(clamp_act(int'(num_active), NUM_CH));

    always_comb begin
        w_ptr_empty = 1'b1;
        w_ret_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ptr == CH_W'(i))
                w_ptr_empty = fifo_empty[i];
            if (r_ch_d == CH_W'(i))
                w_ret_data = fifo_rdata[i*DATA_W +: DATA_W];
        end
    end

    // A pop this cycle frees a slot in time for the word issued now, giving 1 word/cycle.
    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_credit  = (({1'b0, w_count} + (CNT_W+1)'(r_infl) - (CNT_W+1)'(w_pop))
                        < (CNT_W+1)'(SKID_DEPTH));

    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (enable && !frame_sync) w_next = RUN;
            RUN: begin
                if (frame_sync)
                    w_next = FLUSH;
                else if (!enable)
                    w_next = IDLE;
            end
            FLUSH:   if (!frame_sync) w_next = enable ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // No reads once frame_sync is up: anything returned would be thrown away.
    always_comb begin
        w_issue    = 1'b0;
        w_flush    = 1'b0;
        fifo_rd_en = '0;
        case (r_state)
            RUN: begin
                w_issue = !frame_sync && !w_ptr_empty && w_credit;
                w_flush = frame_sync;
            end
            FLUSH:   w_flush = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++)
            fifo_rd_en[i] = w_issue && (r_ptr == CH_W'(i));
    end

    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_act_lat  <= CH_W'(1);
            r_infl     <= 1'b0;
            r_ch_d     <= '0;
            r_rd_seen  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_infl <= w_issue;
            r_ch_d <= r_ptr;
            if (r_state == FLUSH) begin
                r_ptr      <= '0;
                r_act_lat  <= w_act_new;
                r_rd_seen  <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                // A pointer left beyond a smaller panel count would never find a valid FIFO.
                if (r_state == IDLE && w_next == RUN) begin
                    r_act_lat <= w_act_new;
                    if (r_ptr >= w_act_new)
                        r_ptr <= '0;
                end
                if (w_issue) begin
                    r_ptr     <= (r_ptr == r_act_lat - CH_W'(1)) ? '0 : r_ptr + CH_W'(1);
                    r_rd_seen <= 1'b1;
                end
                if (r_state == RUN && out_ready && !out_valid && r_rd_seen)
                    r_underrun <= 1'b1;
            end
        end
    end

    assign w_push          = r_infl && !w_flush;
    assign w_push_ent.data = w_ret_data;
    assign w_push_ent.ch   = r_ch_d;

    lcd_skid_q #(
        .DEPTH (SKID_DEPTH),
        .W     ($bits(q_entry_t))
    ) u_skid_q (
        .ahb_clk_intf (ahb_clk_intf),
        .reset        (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_flush      (w_flush),
        .i_wdata      (w_push_ent),
        .o_rdata      (w_head),
        .o_count      (w_count)
    );

    assign out_data = w_head.data;
    assign out_ch   = w_head.ch;
    assign underrun = r_underrun;

`ifdef LCD_ARB_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [31:0] r_words_cnt;

    always_ff @(posedge ahb_clk_intf or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_words_cnt <= '0;
        end else if (r_state == FLUSH) begin
            r_stall_cnt <= '0;
            r_words_cnt <= '0;
        end else begin
            if (r_state == RUN && w_ptr_empty && w_credit && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_pop)
                r_words_cnt <= r_words_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign words_cnt = r_words_cnt;
`endif

endmodule

// File: tb/tb_lcd_panel_rd_arb.sv
// Self-checking bench: directed table/sequences plus random traffic against a queue-based model.
module tb_lcd_panel_rd_arb;

    localparam int NCH = 3;
    localparam int DW  = 32;
    localparam int SD  = 2;
    localparam int CHW = 3;
    localparam int NAW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              frame_sync = 1'b0;
    logic              out_ready = 1'b0;
    logic [NAW-1:0]    num_active = 2'd2;
    logic [NCH-1:0]    fifo_empty = '1;
    logic [NCH-1:0]    hold = '0;
    logic [NCH*DW-1:0] fifo_rdata = '0;
    logic [NCH-1:0]    fifo_rd_en;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic              underrun;
`ifdef LCD_ARB_STATS_EN
    logic [15:0]       stall_cnt;
    logic [31:0]       words_cnt;
`endif

    always #5 clk = ~clk;

    lcd_panel_rd_arb #(.NUM_CH(NCH), .DATA_W(DW), .SKID_DEPTH(SD)) dut (
        .ahb_clk_intf (clk),
        .reset        (rst),
        .enable       (enable),
        .num_active   (num_active),
        .frame_sync   (frame_sync),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_ready    (out_ready),
        .underrun     (underrun)
`ifdef LCD_ARB_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .words_cnt    (words_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [CHW-1:0] ch;
    } ent_t;

    typedef struct {
        logic [NCH-1:0] rd;
        logic           v;
        logic [CHW-1:0] ch;
        logic [DW-1:0]  d;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0]  fq [NCH][$];
    ent_t           mq [$];
    ent_t           pend [$];
    bit             m_run, m_fl, m_seen, m_und;
    int             m_ptr, m_act;
    int             m_words, m_stall;
    logic [DW-1:0]  log_d [$];
    logic [CHW-1:0] log_c [$];
    int             n_rd [NCH];
    logic [NCH-1:0] rd_cap;

    function automatic logic [DW-1:0] wd(input int ch, input int k);
        return 32'hD000_0000 | DW'(ch << 16) | DW'(k);
    endfunction

    function automatic int clampf(input int n);
        if (n == 0) return 1;
        if (n > NCH) return NCH;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < NCH; i++)
            fifo_empty[i] = (fq[i].size() == 0) || hold[i];
    endtask

    task automatic fill(input int ch, input int n);
        int base;
        base = fq[ch].size() + 100 * n_rd[ch];
        for (int k = 0; k < n; k++)
            fq[ch].push_back(wd(ch, base + k));
        upd_empty();
    endtask

    task automatic model_reset();
        m_run = 0; m_fl = 0; m_seen = 0; m_und = 0;
        m_ptr = 0; m_act = 1; m_words = 0; m_stall = 0;
        mq.delete();
        pend.delete();
    endtask

    function automatic bit m_pop();
        return out_ready && (mq.size() > 0);
    endfunction

    function automatic bit m_credit();
        return (mq.size() + pend.size() - int'(m_pop())) < SD;
    endfunction

    function automatic bit m_issue();
        return m_run && !frame_sync && !fifo_empty[m_ptr] && m_credit();
    endfunction

    task automatic check_model();
        logic [NCH-1:0] exp_rd;
        exp_rd = '0;
        if (m_issue()) exp_rd[m_ptr] = 1'b1;
        chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0].d));
            chk("out_ch", 64'(out_ch), 64'(mq[0].ch));
        end
        chk("underrun", 64'(underrun), 64'(m_und));
`ifdef LCD_ARB_STATS_EN
        chk("words_cnt", 64'(words_cnt), 64'(m_words));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        rd_cap = fifo_rd_en;
        for (int i = 0; i < NCH; i++)
            if (fifo_rd_en[i]) n_rd[i]++;
        if (out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_c.push_back(out_ch);
        end
    endtask

    task automatic m_step();
        bit fl, iss, pp, und_set;
        int na;
        fl = m_fl || (m_run && frame_sync);
        iss = m_issue();
        pp = m_pop();
        na = clampf(int'(num_active));
        und_set = m_run && out_ready && (mq.size() == 0) && m_seen;
`ifdef LCD_ARB_STATS_EN
        if (m_fl) begin
            m_words = 0; m_stall = 0;
        end else begin
            if (m_run && fifo_empty[m_ptr] && m_credit() && m_stall < 16'hFFFF) m_stall++;
            if (pp) m_words++;
        end
`endif
        if (fl) begin
            mq.delete();
            pend.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (pend.size() > 0) mq.push_back(pend.pop_front());
        end
        if (iss) begin
            pend.push_back('{d: fq[m_ptr][0], ch: CHW'(m_ptr)});
            m_seen = 1;
            m_ptr = (m_ptr + 1) % m_act;
        end
        if (und_set) m_und = 1;
        if (m_fl) begin
            m_ptr = 0; m_act = na; m_seen = 0; m_und = 0;
            if (!frame_sync) begin
                m_fl = 0;
                m_run = enable;
            end
        end else if (m_run) begin
            if (frame_sync) begin
                m_run = 0; m_fl = 1;
            end else if (!enable) m_run = 0;
        end else if (enable && !frame_sync) begin
            m_run = 1; m_act = na;
            if (m_ptr >= na) m_ptr = 0;
        end
    endtask

    // Inputs are set at the falling edge; compare, clock, advance model, then let the FIFOs answer.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        m_step();
        #1;
        for (int i = 0; i < NCH; i++)
            if (rd_cap[i] && fq[i].size() > 0)
                fifo_rdata[i*DW +: DW] = fq[i].pop_front();
        upd_empty();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        enable = 0; frame_sync = 0; out_ready = 0; hold = '0;
        for (int i = 0; i < NCH; i++) begin
            fq[i].delete();
            n_rd[i] = 0;
        end
        fifo_rdata = '0;
        log_d.delete();
        log_c.delete();
        upd_empty();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tv [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit found;
        int issued;

        tv[0]  = '{3'b001, 1'b0, 3'd0, 32'd0};
        tv[1]  = '{3'b010, 1'b0, 3'd0, 32'd0};
        tv[2]  = '{3'b001, 1'b1, 3'd0, wd(0, 0)};
        tv[3]  = '{3'b010, 1'b1, 3'd1, wd(1, 0)};
        tv[4]  = '{3'b001, 1'b1, 3'd0, wd(0, 1)};
        tv[5]  = '{3'b010, 1'b1, 3'd1, wd(1, 1)};
        tv[6]  = '{3'b001, 1'b1, 3'd0, wd(0, 2)};
        tv[7]  = '{3'b010, 1'b1, 3'd1, wd(1, 2)};
        tv[8]  = '{3'b000, 1'b1, 3'd0, wd(0, 3)};
        tv[9]  = '{3'b000, 1'b1, 3'd1, wd(1, 3)};
        tv[10] = '{3'b000, 1'b0, 3'd0, 32'd0};

        #2;
        do_reset();
        #1;
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ch", 64'(out_ch), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        @(negedge clk);

        // Two panels interleaved at full rate
        num_active = 2'd2;
        fill(0, 4); fill(1, 4);
        out_ready = 1; enable = 1;
        tick();
        for (int k = 0; k < 11; k++) begin
            #1;
            chk("tbl_rd_en", 64'(fifo_rd_en), 64'(tv[k].rd));
            chk("tbl_valid", 64'(out_valid), 64'(tv[k].v));
            if (tv[k].v) begin
                chk("tbl_data", 64'(out_data), 64'(tv[k].d));
                chk("tbl_ch", 64'(out_ch), 64'(tv[k].ch));
            end
            tick();
        end

        // Single active panel ignores ch1, then runs dry
        do_reset();
        num_active = 2'd1;
        fill(0, 3); fill(1, 5);
        out_ready = 1; enable = 1;
        ticks(12);
        chk("single_rd1", 64'(n_rd[1]), 64'd0);
        chk("single_words", 64'(log_d.size()), 64'd3);
        chk("single_underrun", 64'(underrun), 64'd1);

        // Strict order: stall on empty ch1 without skipping to ch0
        do_reset();
        num_active = 2'd2;
        fill(0, 2); fill(1, 2);
        hold[1] = 1'b1; upd_empty();
        out_ready = 1; enable = 1;
        ticks(2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        hold[1] = 1'b0; upd_empty();
        ticks(10);
        chk("order_n", 64'(log_d.size()), 64'd4);
        if (log_d.size() >= 3) begin
            chk("order_0", 64'(log_d[0]), 64'(wd(0, 0)));
            chk("order_1", 64'(log_d[1]), 64'(wd(1, 0)));
            chk("order_2", 64'(log_d[2]), 64'(wd(0, 1)));
        end

        // Backpressure: credit stops issue at SKID_DEPTH reads
        do_reset();
        num_active = 2'd2;
        fill(0, 4); fill(1, 4);
        out_ready = 0; enable = 1;
        ticks(8);
        chk("bp_issued", 64'(n_rd[0] + n_rd[1]), 64'd2);
        out_ready = 1;
        ticks(15);
        chk("bp_words", 64'(log_d.size()), 64'd8);
        for (int k = 0; k < 8 && k < log_d.size(); k++)
            chk("bp_seq", 64'(log_d[k]), 64'(wd(k % 2, k / 2)));

        // frame_sync flush with queue full; num_active 2->3 takes effect
        do_reset();
        num_active = 2'd2;
        fill(0, 6); fill(1, 6); fill(2, 6);
        out_ready = 1; enable = 1;
        ticks(4);
        out_ready = 0;
        ticks(4);
        frame_sync = 1; num_active = 2'd3;
        tick();
        #1;
        chk("fs_valid", 64'(out_valid), 64'd0);
        ticks(2);
        frame_sync = 0;
        log_d.delete(); log_c.delete();
        out_ready = 1;
        #1;
        chk("fs_underrun", 64'(underrun), 64'd0);
        ticks(12);
        found = 0;
        foreach (log_c[k]) if (log_c[k] == 3'd2) found = 1;
        chk("fs_first_ch", 64'(log_c.size() > 0 ? log_c[0] : 3'd7), 64'd0);
        chk("fs_ch2_seen", 64'(found), 64'd1);

        // Asynchronous reset mid-burst
        do_reset();
        num_active = 2'd2;
        fill(0, 5); fill(1, 5);
        out_ready = 1; enable = 1;
        ticks(6);
        #2;
        rst = 1'b1;
        model_reset();
        enable = 0;
        #1;
        chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_ch", 64'(out_ch), 64'd0);
        chk("arst_underrun", 64'(underrun), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) n_rd[i] = 0;
        ticks(4);
        issued = n_rd[0] + n_rd[1] + n_rd[2];
        chk("arst_no_rd", 64'(issued), 64'd0);
        enable = 1;
        ticks(10);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 24) != 0);
            frame_sync = frame_sync ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
            num_active = NAW'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++) begin
                hold[i] = ($urandom_range(0, 7) == 0);
                if (fq[i].size() < 2 && $urandom_range(0, 2) == 0)
                    fill(i, $urandom_range(1, 4));
            end
            upd_empty();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
